// File: rtl/wb_req_bridge_pkg.sv
// Shared types and constants for the core-request to Wishbone bridge.
//   state_t          : bridge sequencing states
//   ERR_DATA_DEFAULT : read data returned when the bus times out
//   sel_width()      : byte-select width for a given data width
package wb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

   function automatic int sel_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/wb_req_bridge_if.sv
// Wishbone classic bus between the bridge (master) and memory/controller (slave).
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o : master -> slave
//   wb_dat_i, wb_ack_i                                         : slave -> master
interface wb_req_bridge_if
   import wb_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);

   localparam int SEL_WIDTH = sel_width(DATA_WIDTH);

   logic                  wb_cyc_o;
   logic                  wb_stb_o;
   logic                  wb_we_o;
   logic [SEL_WIDTH-1:0]  wb_sel_o;
   logic [ADDR_WIDTH-1:0] wb_adr_o;
   logic [DATA_WIDTH-1:0] wb_dat_o;
   logic [DATA_WIDTH-1:0] wb_dat_i;
   logic                  wb_ack_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
      output wb_dat_i, wb_ack_i
   );

endinterface

// File: rtl/wb_req_bridge_timeout_ctr.sv
// Bus timeout timer: down-counter reloaded by clear, decremented by enable,
// terminal count at zero. Holds at zero once reached. Inert (expired never
// asserts) when TIMEOUT_CYCLES is 0.
//   clk, rst : clock, synchronous active-high reset
//   clear    : reload to TIMEOUT_CYCLES-1
//   enable   : count one bus cycle
//   expired  : last allowed bus cycle reached
module wb_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LOAD = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= LOAD;
      end else if (enable && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Zero after TIMEOUT_CYCLES-1 decrements, i.e. on the final bus cycle.
   assign expired = (TIMEOUT_CYCLES != 0) && (cnt == '0);

endmodule

// File: rtl/wb_req_bridge.sv
// Core request/ack port to registered Wishbone classic master. One request is
// captured, driven on the bus until wb_ack_i or timeout, and answered with a
// single-cycle m_ack. All outputs are registered.
//   clk, rst           : clock, synchronous active-high reset
//   m_req/we/sel/addr/wdata : core request, m_req held until m_ack
//   m_ack, m_rdata, m_err   : core response (m_err flags a timeout)
//   err_sticky              : any timeout since reset
//   wb                      : Wishbone master port
//
// state | meaning
// IDLE  | no bus cycle; accept m_req
// BUS   | cyc/stb driven, waiting for wb_ack_i or timeout
// RESP  | m_ack pulse to the core; one-cycle gap before next request
module wb_req_bridge
   import wb_bridge_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    TIMEOUT_CYCLES = 255,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 m_req,
   input  logic                                 m_we,
   input  logic [sel_width(DATA_WIDTH)-1:0]     m_sel,
   input  logic [ADDR_WIDTH-1:0]                m_addr,
   input  logic [DATA_WIDTH-1:0]                m_wdata,
   output logic                                 m_ack,
   output logic [DATA_WIDTH-1:0]                m_rdata,
   output logic                                 m_err,
   output logic                                 err_sticky,
   wb_req_bridge_if.master                      wb
);

   localparam int SEL_WIDTH = sel_width(DATA_WIDTH);

   state_t state, state_n;

   logic                  cyc_q,    cyc_n;
   logic                  we_q,     we_n;
   logic [SEL_WIDTH-1:0]  sel_q,    sel_n;
   logic [ADDR_WIDTH-1:0] adr_q,    adr_n;
   logic [DATA_WIDTH-1:0] dat_q,    dat_n;
   logic                  ack_q,    ack_n;
   logic                  err_q,    err_n;
   logic [DATA_WIDTH-1:0] rdata_q,  rdata_n;
   logic                  sticky_q, sticky_n;

   logic expired;

   // Timer reloads every cycle outside BUS, so it is fresh on bus entry.
   wb_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk     (clk),
      .rst     (rst),
      .clear   (state != BUS),
      .enable  (state == BUS),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (m_req) state_n = BUS;
         BUS:     if (wb.wb_ack_i || expired) state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      cyc_n    = cyc_q;
      we_n     = we_q;
      sel_n    = sel_q;
      adr_n    = adr_q;
      dat_n    = dat_q;
      ack_n    = 1'b0;
      err_n    = 1'b0;
      rdata_n  = rdata_q;
      sticky_n = sticky_q;
      case (state)
         IDLE: begin
            if (m_req) begin
               cyc_n = 1'b1;
               we_n  = m_we;
               sel_n = m_sel;
               adr_n = m_addr;
               dat_n = m_wdata;
            end
         end
         BUS: begin
            // Slave ack takes priority over a timeout in the same cycle.
            if (wb.wb_ack_i) begin
               cyc_n   = 1'b0;
               ack_n   = 1'b1;
               rdata_n = wb.wb_dat_i;
            end else if (expired) begin
               cyc_n    = 1'b0;
               ack_n    = 1'b1;
               err_n    = 1'b1;
               rdata_n  = ERR_DATA;
               sticky_n = 1'b1;
            end
         end
         default: cyc_n = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         sel_q    <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         sticky_q <= 1'b0;
      end else begin
         cyc_q    <= cyc_n;
         we_q     <= we_n;
         sel_q    <= sel_n;
         adr_q    <= adr_n;
         dat_q    <= dat_n;
         ack_q    <= ack_n;
         err_q    <= err_n;
         rdata_q  <= rdata_n;
         sticky_q <= sticky_n;
      end
   end

   assign wb.wb_cyc_o = cyc_q;
   assign wb.wb_stb_o = cyc_q;
   assign wb.wb_we_o  = we_q;
   assign wb.wb_sel_o = sel_q;
   assign wb.wb_adr_o = adr_q;
   assign wb.wb_dat_o = dat_q;

   assign m_ack      = ack_q;
   assign m_err      = err_q;
   assign m_rdata    = rdata_q;
   assign err_sticky = sticky_q;

endmodule
